// File: rtl/sha_core_arbiter_pkg.sv
// Shared types for the SHA core arbiter: widths, FSM states, index helpers.
package sha_core_arbiter_pkg;

  localparam int BLOCK_W  = 512;
  localparam int DIGEST_W = 256;
  localparam int IDX_W    = 2;

  typedef logic [IDX_W-1:0] req_idx_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic req_idx_t wrap_inc(req_idx_t i, int n);
    return (int'(i) == n - 1) ? '0 : i + 1'b1;
  endfunction

endpackage

// File: rtl/sha_core_arbiter_rr_arb.sv
// Rotating-priority picker: first asserted request at or after ptr, wrapping.
module sha_core_arbiter_rr_arb
  import sha_core_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output logic               valid,
  output req_idx_t           grant
);

  // Descending offset scan so the smallest offset from ptr wins.
  always_comb begin
    valid = 1'b0;
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req[r] && (r == (int'(ptr) + k) % NUM_REQ)) begin
          valid = 1'b1;
          grant = req_idx_t'(r);
        end
      end
    end
  end

endmodule

// File: rtl/sha_core_arbiter.sv
// Shares one SHA-256 core among NUM_REQ requesters with round-robin grant
// and a watchdog that drops jobs whose core never signals done.
module sha_core_arbiter
  import sha_core_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic [NUM_REQ-1:0]         i_fReq,
  input  logic [NUM_REQ*BLOCK_W-1:0] i_Data,
  output logic [NUM_REQ-1:0]         o_fAck,
  output logic [NUM_REQ-1:0]         o_fDone,
  output logic [NUM_REQ-1:0]         o_fErr,
  output logic [DIGEST_W-1:0]        o_Data,
  output logic [BLOCK_W-1:0]         o_CoreData,
  output logic                       o_fCoreStart,
  input  logic [DIGEST_W-1:0]        i_CoreData,
  input  logic                       i_fCoreDone
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  state_t   state, state_n;
  req_idx_t gnt, gnt_n;
  req_idx_t ptr, ptr_n;
  logic [7:0] wdog, wdog_n, wdog_inc;

  logic [BLOCK_W-1:0]  core_data_n;
  logic [DIGEST_W-1:0] dig_n;
  logic [NUM_REQ-1:0]  ack_n, done_n, err_n;
  logic [NUM_REQ-1:0]  arb_oh, cur_oh;
  logic                start_n;

  logic     arb_valid;
  req_idx_t arb_gnt;

  sha_core_arbiter_rr_arb #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req  (i_fReq),
    .ptr  (ptr),
    .valid(arb_valid),
    .grant(arb_gnt)
  );

  always_comb begin
    for (int r = 0; r < NUM_REQ; r++) begin
      arb_oh[r] = (req_idx_t'(r) == arb_gnt);
      cur_oh[r] = (req_idx_t'(r) == gnt);
    end
  end

  always_comb begin
    state_n     = state;
    gnt_n       = gnt;
    ptr_n       = ptr;
    wdog_n      = wdog;
    wdog_inc    = wdog + 8'd1;
    core_data_n = o_CoreData;
    dig_n       = o_Data;
    ack_n       = '0;
    done_n      = '0;
    err_n       = '0;
    start_n     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_n       = arb_gnt;
          ptr_n       = wrap_inc(arb_gnt, NUM_REQ);
          core_data_n = i_Data[int'(arb_gnt)*BLOCK_W +: BLOCK_W];
          ack_n       = arb_oh;
          start_n     = 1'b1;
          state_n     = ST_START;
        end
      end
      ST_START: begin
        wdog_n  = '0;
        state_n = ST_WAIT;
      end
      // Done is checked first so it wins over a same-cycle expiry.
      ST_WAIT: begin
        wdog_n = wdog_inc;
        if (i_fCoreDone) begin
          dig_n   = i_CoreData;
          done_n  = cur_oh;
          state_n = ST_DONE;
        end else if (wdog_inc == TO_CNT) begin
          err_n   = cur_oh;
          state_n = ST_ERR;
        end
      end
      ST_DONE, ST_ERR: state_n = ST_IDLE;
      default:         state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= ST_IDLE;
      gnt          <= '0;
      ptr          <= '0;
      wdog         <= '0;
      o_CoreData   <= '0;
      o_Data       <= '0;
      o_fAck       <= '0;
      o_fDone      <= '0;
      o_fErr       <= '0;
      o_fCoreStart <= 1'b0;
    end else begin
      state        <= state_n;
      gnt          <= gnt_n;
      ptr          <= ptr_n;
      wdog         <= wdog_n;
      o_CoreData   <= core_data_n;
      o_Data       <= dig_n;
      o_fAck       <= ack_n;
      o_fDone      <= done_n;
      o_fErr       <= err_n;
      o_fCoreStart <= start_n;
    end
  end

endmodule
